// File: rtl/fpu_seq.sv
// fpu_seq: issue sequencer between the core's FPU decode and the floating-point
// IP units (fadd_fsub, fmul, multicycle fdiv). One operation in flight at a time.
//
// State table:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | ready for a request; MOV and illegal ops complete from here
//   S_ISSUE | selected unit's tvalid is high for this single cycle
//   S_WAIT  | waiting on the selected unit's result valid, bounded by timeout
//   S_RESP  | one-cycle response to the core; stall drops so the core commits
//
// Ports:
//   CLK, RST_N                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in S_IDLE)
//   req_op, req_a, req_b, req_rd    op code (0 ADD,1 SUB,2 MUL,3 DIV,4 MOV), operands, dest FPR
//   add_tvalid, add_opcode          adder input valid, {7'b0, sub}
//   mul_tvalid, div_tvalid          multiplier / divider input valids
//   op_a, op_b                      registered operands shared by all units
//   *_res_tvalid, *_res             unit results
//   stall                           core holds PC and does not commit
//   resp_valid/data/rd/err          one-cycle completion
module fpu_seq #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        add_tvalid,
  output logic [7:0]  add_opcode,
  output logic        mul_tvalid,
  output logic        div_tvalid,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        add_res_tvalid,
  input  logic        mul_res_tvalid,
  input  logic        div_res_tvalid,
  input  logic [31:0] add_res,
  input  logic [31:0] mul_res,
  input  logic [31:0] div_res,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 127) ? $clog2(TIMEOUT_CYC) : 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOV = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              add_tvalid_q, add_tvalid_d;
  logic              add_sub_q, add_sub_d;
  logic              mul_tvalid_q, mul_tvalid_d;
  logic              div_tvalid_q, div_tvalid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Only the unit that was issued to may complete the operation.
  logic        sel_res_valid;
  logic [31:0] sel_res;

  always_comb begin
    sel_res_valid = 1'b0;
    sel_res       = 32'h0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        sel_res_valid = add_res_tvalid;
        sel_res       = add_res;
      end
      OP_MUL: begin
        sel_res_valid = mul_res_tvalid;
        sel_res       = mul_res;
      end
      OP_DIV: begin
        sel_res_valid = div_res_tvalid;
        sel_res       = div_res;
      end
      default: begin
        sel_res_valid = 1'b0;
        sel_res       = 32'h0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rd_d         = rd_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    add_tvalid_d = 1'b0;
    add_sub_d    = 1'b0;
    mul_tvalid_d = 1'b0;
    div_tvalid_d = 1'b0;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          op_a_d = req_a;
          op_b_d = req_b;
          rd_d   = req_rd;
          // Unit valids are registered so they line up with the ISSUE cycle.
          case (req_op)
            OP_ADD, OP_SUB: begin
              add_tvalid_d = 1'b1;
              add_sub_d    = (req_op == OP_SUB);
              state_d      = S_ISSUE;
            end
            OP_MUL: begin
              mul_tvalid_d = 1'b1;
              state_d      = S_ISSUE;
            end
            OP_DIV: begin
              div_tvalid_d = 1'b1;
              state_d      = S_ISSUE;
            end
            OP_MOV: begin
              resp_data_d  = req_b;
              resp_valid_d = 1'b1;
              state_d      = S_RESP;
            end
            default: begin
              resp_data_d  = QNAN;
              resp_err_d   = 1'b1;
              resp_valid_d = 1'b1;
              state_d      = S_RESP;
            end
          endcase
        end
      end

      S_ISSUE: begin
        // A combinational IP can answer in the same cycle it sees tvalid.
        if (sel_res_valid) begin
          resp_data_d  = sel_res;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (sel_res_valid) begin
          resp_data_d  = sel_res;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_data_d  = QNAN;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      op_a_q       <= 32'h0;
      op_b_q       <= 32'h0;
      rd_q         <= 5'd0;
      resp_data_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      add_tvalid_q <= 1'b0;
      add_sub_q    <= 1'b0;
      mul_tvalid_q <= 1'b0;
      div_tvalid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rd_q         <= rd_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      add_tvalid_q <= add_tvalid_d;
      add_sub_q    <= add_sub_d;
      mul_tvalid_q <= mul_tvalid_d;
      div_tvalid_q <= div_tvalid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  // Stall rises combinationally with the request so the core holds PC
  // in the very cycle it is accepted; it drops in RESP to let the core commit.
  assign stall      = ((state_q == S_IDLE) && req_valid) ||
                      (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign add_tvalid = add_tvalid_q;
  assign add_opcode = {7'b0, add_sub_q};
  assign mul_tvalid = mul_tvalid_q;
  assign div_tvalid = div_tvalid_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = rd_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_fpu_seq.sv
`timescale 1ns/1ps
module tb_fpu_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, to_req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;

  logic        req_ready, add_tvalid, mul_tvalid, div_tvalid, stall;
  logic [7:0]  add_opcode;
  logic [31:0] op_a, op_b, resp_data;
  logic        resp_valid, resp_err;
  logic [4:0]  resp_rd;
  logic        add_res_tvalid, mul_res_tvalid, div_res_tvalid;
  logic [31:0] add_res, mul_res, div_res;

  logic        to_req_ready, to_add_tvalid, to_mul_tvalid, to_div_tvalid, to_stall;
  logic [7:0]  to_add_opcode;
  logic [31:0] to_op_a, to_op_b, to_resp_data;
  logic        to_resp_valid, to_resp_err;
  logic [4:0]  to_resp_rd;
  logic        to_div_res_tvalid;

  always #5 CLK = ~CLK;

  fpu_seq dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .add_tvalid(add_tvalid), .add_opcode(add_opcode),
    .mul_tvalid(mul_tvalid), .div_tvalid(div_tvalid),
    .op_a(op_a), .op_b(op_b),
    .add_res_tvalid(add_res_tvalid), .mul_res_tvalid(mul_res_tvalid),
    .div_res_tvalid(div_res_tvalid),
    .add_res(add_res), .mul_res(mul_res), .div_res(div_res),
    .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err)
  );

  // Second instance with a short timeout; only its divider result is driven.
  fpu_seq #(.TIMEOUT_CYC(8)) dut_to (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(to_req_valid), .req_ready(to_req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .add_tvalid(to_add_tvalid), .add_opcode(to_add_opcode),
    .mul_tvalid(to_mul_tvalid), .div_tvalid(to_div_tvalid),
    .op_a(to_op_a), .op_b(to_op_b),
    .add_res_tvalid(1'b0), .mul_res_tvalid(1'b0),
    .div_res_tvalid(to_div_res_tvalid),
    .add_res(32'h0), .mul_res(32'h0), .div_res(32'h1234_5678),
    .stall(to_stall), .resp_valid(to_resp_valid), .resp_data(to_resp_data),
    .resp_rd(to_resp_rd), .resp_err(to_resp_err)
  );

  // Known IEEE-754 single results for the operand pairs used below.
  function automatic logic [31:0] fadd_lut(input logic [31:0] a, input logic [31:0] b, input logic sub);
    if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if ( sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'hBF80_0000;
    if (!sub && a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
    if ( sub && a == 32'h4000_0000 && b == 32'h3F80_0000) return 32'h3F80_0000;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] fmul_lut(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC0_0000 && b == 32'h4080_0000) return 32'h40C0_0000;
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] fdiv_lut(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4120_0000 && b == 32'h4000_0000) return 32'h40A0_0000;
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return 32'hDEAD_BEEF;
  endfunction

  // Unit models: latency 0 answers combinationally, latency N raises result
  // valid N cycles after the input tvalid. Strays inject unrelated valids.
  int add_lat = 0, mul_lat = 0, div_lat = 0;
  int add_left = 0, mul_left = 0, div_left = 0;
  logic [31:0] add_la, add_lb, mul_la, mul_lb, div_la, div_lb;
  logic add_lsub;
  logic add_stray = 1'b0, mul_stray = 1'b0;

  always @(posedge CLK) begin
    if (add_tvalid === 1'b1) begin
      add_left <= add_lat; add_la <= op_a; add_lb <= op_b; add_lsub <= add_opcode[0];
    end else if (add_left > 0) add_left <= add_left - 1;
    if (mul_tvalid === 1'b1) begin
      mul_left <= mul_lat; mul_la <= op_a; mul_lb <= op_b;
    end else if (mul_left > 0) mul_left <= mul_left - 1;
    if (div_tvalid === 1'b1) begin
      div_left <= div_lat; div_la <= op_a; div_lb <= op_b;
    end else if (div_left > 0) div_left <= div_left - 1;
  end

  assign add_res_tvalid = ((add_lat == 0) ? add_tvalid : (add_left == 1)) | add_stray;
  assign mul_res_tvalid = ((mul_lat == 0) ? mul_tvalid : (mul_left == 1)) | mul_stray;
  assign div_res_tvalid = (div_lat == 0) ? div_tvalid : (div_left == 1);
  assign add_res = (add_lat == 0) ? fadd_lut(op_a, op_b, add_opcode[0]) : fadd_lut(add_la, add_lb, add_lsub);
  assign mul_res = (mul_lat == 0) ? fmul_lut(op_a, op_b) : fmul_lut(mul_la, mul_lb);
  assign div_res = (div_lat == 0) ? fdiv_lut(op_a, op_b) : fdiv_lut(div_la, div_lb);

  int total = 0, bad = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  logic mon_on = 1'b0;

  always @(negedge CLK) begin
    if (mon_on) begin
      if (resp_valid === 1'b1) begin
        if (sb_q.size() == 0) chk1("unexpected_resp", resp_valid, 1'b0);
        else begin
          mon_e = sb_q.pop_front();
          chk("resp_cycle", cyc, mon_e.cyc);
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_rd", 32'(resp_rd), 32'(mon_e.rd));
          chk1("resp_err", resp_err, mon_e.err);
        end
      end else begin
        chk1("err_without_valid", resp_err, 1'b0);
      end
    end
  end

  int n_add = 0, n_mul = 0, n_div = 0;
  logic [7:0] last_opcode = 8'h0;
  always @(negedge CLK) begin
    if (add_tvalid === 1'b1) begin n_add++; last_opcode = add_opcode; end
    if (mul_tvalid === 1'b1) n_mul++;
    if (div_tvalid === 1'b1) n_div++;
  end

  int to_n = 0, to_cyc = 0;
  logic [31:0] to_data;
  logic to_err;
  logic [4:0] to_rd;
  always @(negedge CLK) begin
    if (to_resp_valid === 1'b1) begin
      to_n++; to_cyc = cyc; to_data = to_resp_data; to_err = to_resp_err; to_rd = to_resp_rd;
    end
  end

  task automatic clr_counts();
    n_add = 0; n_mul = 0; n_div = 0; last_opcode = 8'h0;
  endtask

  // Called at a negedge; drives one request for one cycle and queues its
  // expected response 'lat' cycles after the accepting cycle.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input int lat, input logic [31:0] data,
                      input logic err, output int t);
    exp_t e;
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
    chk1("ready_wait", req_ready, 1'b1);
    req_op = op; req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
    t = cyc;
    e.cyc = cyc + lat; e.data = data; e.rd = rd; e.err = err;
    sb_q.push_back(e);
    #1 chk1("accept_stall", stall, 1'b1);
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 400) begin @(negedge CLK); n++; end
    chk("drain", sb_q.size(), 0);
    if (sb_q.size() > 0) sb_q.delete();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] data;
    logic        err;
  } vec_t;
  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, t3, elat, n;
    logic [2:0] vop;
    logic is_add;

    vecs[0]  = '{3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5,  0, 32'h4040_0000, 1'b0};
    vecs[1]  = '{3'd1, 32'h3F80_0000, 32'h4000_0000, 5'd6,  0, 32'hBF80_0000, 1'b0};
    vecs[2]  = '{3'd0, 32'h4000_0000, 32'h4000_0000, 5'd0,  2, 32'h4080_0000, 1'b0};
    vecs[3]  = '{3'd2, 32'h3FC0_0000, 32'h4080_0000, 5'd7,  0, 32'h40C0_0000, 1'b0};
    vecs[4]  = '{3'd2, 32'h4000_0000, 32'h4040_0000, 5'd8,  3, 32'h40C0_0000, 1'b0};
    vecs[5]  = '{3'd3, 32'h4120_0000, 32'h4000_0000, 5'd9,  1, 32'h40A0_0000, 1'b0};
    vecs[6]  = '{3'd3, 32'h40C0_0000, 32'h4000_0000, 5'd10, 5, 32'h4040_0000, 1'b0};
    vecs[7]  = '{3'd4, 32'h1111_1111, 32'hC0A0_0000, 5'd31, 0, 32'hC0A0_0000, 1'b0};
    vecs[8]  = '{3'd5, 32'h3F80_0000, 32'h4000_0000, 5'd3,  0, 32'h7FC0_0000, 1'b1};
    vecs[9]  = '{3'd6, 32'h3F80_0000, 32'h4000_0000, 5'd4,  0, 32'h7FC0_0000, 1'b1};
    vecs[10] = '{3'd1, 32'h4000_0000, 32'h3F80_0000, 5'd1,  1, 32'h3F80_0000, 1'b0};

    RST_N = 1'b0; req_valid = 1'b0; to_req_valid = 1'b0; to_div_res_tvalid = 1'b0;
    req_op = 3'd0; req_a = 32'h0; req_b = 32'h0; req_rd = 5'd0;
    repeat (3) @(negedge CLK);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk1("rst_add_tvalid", add_tvalid, 1'b0);
    chk1("rst_mul_tvalid", mul_tvalid, 1'b0);
    chk1("rst_div_tvalid", div_tvalid, 1'b0);
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_op_b", op_b, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_rd", 32'(resp_rd), 32'h0);
    chk("rst_add_opcode", 32'(add_opcode), 32'h0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_to_ready", to_req_ready, 1'b1);
    RST_N = 1'b1;
    mon_on = 1'b1;
    @(negedge CLK);

    // Table-driven single operations.
    for (int i = 0; i < 11; i++) begin
      vop = vecs[i].op;
      is_add = (vop == 3'd0) || (vop == 3'd1);
      add_lat = vecs[i].lat; mul_lat = vecs[i].lat; div_lat = vecs[i].lat;
      clr_counts();
      elat = (vop >= 3'd4) ? 1 : vecs[i].lat + 2;
      send(vop, vecs[i].a, vecs[i].b, vecs[i].rd, elat, vecs[i].data, vecs[i].err, t);
      chk1("issue_add_tvalid", add_tvalid, is_add);
      chk1("issue_mul_tvalid", mul_tvalid, vop == 3'd2);
      chk1("issue_div_tvalid", div_tvalid, vop == 3'd3);
      chk1("issue_stall", stall, vop < 3'd4);
      wait_drain();
      chk("cnt_add", n_add, is_add ? 1 : 0);
      chk("cnt_mul", n_mul, (vop == 3'd2) ? 1 : 0);
      chk("cnt_div", n_div, (vop == 3'd3) ? 1 : 0);
      if (is_add) chk("add_opcode", 32'(last_opcode), (vop == 3'd1) ? 32'h1 : 32'h0);
    end

    // 28-cycle divide with stray valids from the other units during WAIT.
    add_lat = 0; mul_lat = 0; div_lat = 28;
    clr_counts();
    send(3'd3, 32'h40C0_0000, 32'h4000_0000, 5'd12, 30, 32'h4040_0000, 1'b0, t);
    chk1("div28_tvalid", div_tvalid, 1'b1);
    for (int k = 2; k <= 29; k++) begin
      @(negedge CLK);
      add_stray = (k == 10);
      mul_stray = (k == 11);
      chk1("div28_stall", stall, 1'b1);
      if (k == 15) chk("div28_op_a", op_a, 32'h40C0_0000);
    end
    add_stray = 1'b0; mul_stray = 1'b0;
    @(negedge CLK);
    chk1("div28_stall_resp", stall, 1'b0);
    chk1("div28_ready_resp", req_ready, 1'b0);
    wait_drain();
    chk("div28_cnt_div", n_div, 1);
    chk("div28_cnt_add", n_add, 0);
    chk("div28_cnt_mul", n_mul, 0);

    // Reset in the middle of a divide; the divider's late result must be ignored.
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
    req_op = 3'd3; req_a = 32'h40C0_0000; req_b = 32'h4000_0000; req_rd = 5'd9;
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk1("pre_rst_stall", stall, 1'b1);
    RST_N = 1'b0;
    @(negedge CLK);
    chk1("midrst_stall", stall, 1'b0);
    chk1("midrst_resp_valid", resp_valid, 1'b0);
    chk1("midrst_ready", req_ready, 1'b1);
    chk("midrst_op_a", op_a, 32'h0);
    chk("midrst_resp_data", resp_data, 32'h0);
    chk("midrst_resp_rd", 32'(resp_rd), 32'h0);
    RST_N = 1'b1;
    repeat (30) @(negedge CLK);
    chk1("post_rst_idle", req_ready, 1'b1);
    send(3'd4, 32'h0, 32'h3F80_0000, 5'd2, 1, 32'h3F80_0000, 1'b0, t);
    wait_drain();

    // Timeout on the short-timeout instance, then a late divider pulse in IDLE.
    n = 0;
    while (to_req_ready !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
    to_n = 0;
    req_op = 3'd3; req_a = 32'h40C0_0000; req_b = 32'h4000_0000; req_rd = 5'd4;
    to_req_valid = 1'b1;
    t = cyc;
    #1 chk1("to_accept_stall", to_stall, 1'b1);
    @(negedge CLK);
    to_req_valid = 1'b0;
    chk1("to_div_tvalid", to_div_tvalid, 1'b1);
    repeat (12) @(negedge CLK);
    chk("to_resp_count", to_n, 1);
    chk("to_resp_cycle", to_cyc, t + 10);
    chk("to_resp_data", to_data, 32'h7FC0_0000);
    chk1("to_resp_err", to_err, 1'b1);
    chk("to_resp_rd", 32'(to_rd), 32'd4);
    to_div_res_tvalid = 1'b1;
    @(negedge CLK);
    to_div_res_tvalid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("to_late_ignored", to_n, 1);
    chk1("to_stall_idle", to_stall, 1'b0);

    // Back-to-back: MOV, illegal, MUL.
    add_lat = 0; mul_lat = 0; div_lat = 0;
    clr_counts();
    send(3'd4, 32'h0, 32'hC0A0_0000, 5'd31, 1, 32'hC0A0_0000, 1'b0, t1);
    send(3'd7, 32'h3F80_0000, 32'h3F80_0000, 5'd3, 1, 32'h7FC0_0000, 1'b1, t2);
    send(3'd2, 32'h3FC0_0000, 32'h4080_0000, 5'd17, 2, 32'h40C0_0000, 1'b0, t3);
    chk("b2b_gap_mov_ill", t2 - t1, 2);
    chk("b2b_gap_ill_mul", t3 - t2, 2);
    wait_drain();
    chk("b2b_cnt_add", n_add, 0);
    chk("b2b_cnt_div", n_div, 0);
    chk("b2b_cnt_mul", n_mul, 1);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
